data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Parametrised single-port data RAM for the 8-bit microcontroller datapath with a registered read port, read-valid strobe, and a hardware clear sequencer that zero-fills the array after reset or on request. It sits between the core's load/store unit and the data address space, replacing the combinational-read data memory. An optional per-word parity bit flags storage corruption on read.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of words (≥2; need not be a power of two)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  access request, sampled at posedge
- write_enable  in  1  1 = write, 0 = read; qualified by enable
- address  in  $clog2(DEPTH)  word address
- data_in  in  WIDTH  write data
- clear  in  1  one-cycle request to zero-fill the array
- data_out  out  WIDTH  registered read data
- rd_valid  out  1  one-cycle pulse: data_out updated by a read
- busy  out  1  clear sequence in progress; accesses ignored
- parity_err  out  1  pulse with rd_valid when stored parity mismatches

## Operation
- States: SWEEP, IDLE. Reset forces SWEEP with sweep pointer 0.
- SWEEP: each posedge writes 0 (and matching parity) to mem[ptr], ptr++. The posedge writing DEPTH-1 moves to IDLE. enable and clear ignored; busy=1.
- IDLE: clear=1 → SWEEP, ptr=0; any access in that cycle is dropped (clear wins).
- IDLE read (enable=1, write_enable=0): data_out ← mem[address], rd_valid=1 next cycle.
- IDLE write (enable=1, write_enable=1): mem[address] ← data_in; data_out holds, rd_valid=0.
- enable=0: data_out holds its last value; rd_valid=0.
- Address ≥ DEPTH: write dropped; read returns 0 with rd_valid=1, parity_err=0.
- Read of an address written in the previous cycle returns the new data.
- Reset mid-sweep or mid-access: sweep restarts at 0; any in-flight read result is discarded.

## Timing
- Reset values: data_out=0, rd_valid=0, busy=1, parity_err=0, state=SWEEP, ptr=0.
- After rst_n rises: DEPTH posedges of sweep; busy low after the DEPTH-th posedge; first access accepted at posedge DEPTH+1.
- clear accepted at posedge N → busy high after N, low after posedge N+DEPTH.
- Read latency: 1 cycle (request at posedge N, data_out/rd_valid valid after N until N+1).
- Write latency: 0 (array updated at the sampling posedge).
- Back-to-back reads allowed every cycle; rd_valid stays high across consecutive reads.
- busy, rd_valid, parity_err, data_out are registered outputs.

## Configuration
- DATA_MEMORY_PARITY_EN defined: array is WIDTH+1 bits; bit WIDTH stores even parity (XOR of data) on every write and sweep; on read, parity_err=1 with rd_valid when stored bit ≠ XOR of stored data.
- Not defined: array is WIDTH bits; parity_err is tied to 0; all other behaviour identical.

## Test plan
- Reset release, DEPTH=16 → busy=1 for 16 posedges, then 0; read of every address returns 0x00 with rd_valid pulse one cycle after each request.
- Write 0xA5 to addr 3, read addr 3 next cycle → data_out=0xA5, rd_valid=1 one cycle later; idle cycle after → rd_valid=0, data_out stays 0xA5.
- Fill all 16 addresses with addr^0x3C, assert clear with simultaneous write of 0xFF to addr 0 → write dropped, busy 16 cycles, all reads return 0x00.
- DEPTH=12: write 0x77 to addr 13, read addr 13 → data_out=0x00, rd_valid=1; addr 11 unaffected.
- rst_n pulsed low while busy at ptr=7 and during a pending read → data_out=0, rd_valid=0, full 16-cycle sweep repeats.
- With DATA_MEMORY_PARITY_EN: write 0x0F to addr 5, bench flips stored bit 0 via hierarchical deposit, read addr 5 → data_out=0x0E, parity_err=1 with rd_valid; without macro, parity_err stays 0.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if
// Access bus between the load/store unit and the data memory controller.
//   master: drives enable, write_enable, address, data_in, clear
//           and observes data_out, rd_valid, busy, parity_err
//   slave : the memory controller side of the same signals
interface data_memory_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) ();
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             enable;
    logic             write_enable;
    logic [AW-1:0]    address;
    logic [WIDTH-1:0] data_in;
    logic             clear;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             busy;
    logic             parity_err;

    modport master (
        output enable, write_enable, address, data_in, clear,
        input  data_out, rd_valid, busy, parity_err
    );

    modport slave (
        input  enable, write_enable, address, data_in, clear,
        output data_out, rd_valid, busy, parity_err
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
// Single-port data RAM with a registered read port, a read-valid strobe and
// a clear sequencer that zero-fills the array after reset or on request.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (restarts the zero-fill sweep)
//   bus   - data_memory_ctrl_if.slave: enable, write_enable, address,
//           data_in, clear in; data_out, rd_valid, busy, parity_err out
// Optional feature: define DATA_MEMORY_PARITY_EN to store an even-parity bit
// per word and flag mismatches on read via parity_err.
module data_memory_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_memory_ctrl_if.slave     bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DATA_MEMORY_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif
    localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             busy_q, busy_d;
    logic             parity_err_q, parity_err_d;

    logic [MW-1:0]    mem_q [DEPTH];
    logic             wr_en_s;
    logic [AW-1:0]    wr_addr_s;
    logic [MW-1:0]    wr_data_s;
    logic             in_range_s;
    logic [MW-1:0]    rd_word_s;

    // Build the stored word; with parity the top bit is the XOR of the data.
    function automatic logic [MW-1:0] encode_word(input logic [WIDTH-1:0] d);
`ifdef DATA_MEMORY_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

`ifdef DATA_MEMORY_PARITY_EN
    // Even parity over data plus stored bit is zero for an intact word.
    function automatic logic word_corrupt(input logic [MW-1:0] w);
        return ^w;
    endfunction
`endif

    assign in_range_s = ({1'b0, bus.address} < DEPTH_L);
    assign rd_word_s  = mem_q[bus.address];

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SWEEP;
            ptr_q        <= '0;
            data_out_q   <= '0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b1;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            data_out_q   <= data_out_d;
            rd_valid_q   <= rd_valid_d;
            busy_q       <= busy_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Next-state logic: sweep walks ptr to DEPTH-1, clear restarts it.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_SWEEP: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d   = ptr_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (bus.clear) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    // Output logic: array write port and next values of registered outputs.
    always_comb begin
        wr_en_s      = 1'b0;
        wr_addr_s    = ptr_q;
        wr_data_s    = encode_word('0);
        data_out_d   = data_out_q;
        rd_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        busy_d       = (state_d == ST_SWEEP);
        case (state_q)
            ST_SWEEP: begin
                wr_en_s = 1'b1;
            end
            ST_IDLE: begin
                if (bus.clear) begin
                    // clear wins over any access in the same cycle
                    wr_en_s = 1'b0;
                end else if (bus.enable && bus.write_enable) begin
                    if (in_range_s) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = bus.address;
                        wr_data_s = encode_word(bus.data_in);
                    end else begin
                        wr_en_s   = 1'b0;
                    end
                end else if (bus.enable) begin
                    rd_valid_d = 1'b1;
                    if (in_range_s) begin
                        data_out_d = rd_word_s[WIDTH-1:0];
`ifdef DATA_MEMORY_PARITY_EN
                        parity_err_d = word_corrupt(rd_word_s);
`else
                        parity_err_d = 1'b0;
`endif
                    end else begin
                        data_out_d = '0;
                    end
                end else begin
                    rd_valid_d = 1'b0;
                end
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Storage array; contents are initialised by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.busy       = busy_q;
    assign bus.parity_err = parity_err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl
// Self-checking bench for data_memory_ctrl: DEPTH=16 instance for the main
// sequence plus a DEPTH=12 instance for out-of-range addressing. Expected
// values come from a plain array model of the memory contents.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [16];
    logic [7:0] exp_dout;
    logic       exp_rv;

    data_memory_ctrl_if #(.WIDTH(8), .DEPTH(16)) b ();
    data_memory_ctrl_if #(.WIDTH(8), .DEPTH(12)) b12 ();

    data_memory_ctrl #(.WIDTH(8), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    data_memory_ctrl #(.WIDTH(8), .DEPTH(12)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b12)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    endtask

    // One idle-state access on the DEPTH=16 instance, checked against the model.
    task automatic op(input bit en, input bit we, input int a, input logic [7:0] d, input string tag);
        b.enable       = en;
        b.write_enable = we;
        b.address      = a[3:0];
        b.data_in      = d;
        tick();
        if (en && !we) begin
            exp_dout = ref_mem[a];
            exp_rv   = 1'b1;
        end else begin
            exp_rv   = 1'b0;
        end
        if (en && we) ref_mem[a] = d;
        check({tag, ".dout"}, {24'h0, b.data_out}, {24'h0, exp_dout});
        check({tag, ".rv"},   {31'h0, b.rd_valid}, {31'h0, exp_rv});
        check({tag, ".perr"}, {31'h0, b.parity_err}, 32'h0);
        b.enable = 1'b0;
    endtask

    // Busy must stay high for exactly 16 posedges after the sweep starts.
    task automatic sweep_check(input string tag, input bit try_writes);
        for (int k = 1; k <= 16; k++) begin
            b.enable       = try_writes;
            b.write_enable = 1'b1;
            b.address      = 4'($urandom_range(0, 15));
            b.data_in      = 8'hFF;
            tick();
            check(tag, {31'h0, b.busy}, (k < 16) ? 32'h1 : 32'h0);
        end
        b.enable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        b.enable = 1'b0;  b.write_enable = 1'b0; b.address = 4'h0;
        b.data_in = 8'h00; b.clear = 1'b0;
        b12.enable = 1'b0; b12.write_enable = 1'b0; b12.address = 4'h0;
        b12.data_in = 8'h00; b12.clear = 1'b0;
        exp_dout = 8'h00;
        exp_rv   = 1'b0;
        model_clear();

        // Reset values
        repeat (2) tick();
        check("rst.dout", {24'h0, b.data_out}, 32'h0);
        check("rst.rv",   {31'h0, b.rd_valid}, 32'h0);
        check("rst.busy", {31'h0, b.busy},     32'h1);
        check("rst.perr", {31'h0, b.parity_err}, 32'h0);
        rst_n = 1'b1;
        sweep_check("init.busy", 1'b1);

        // Every address reads back zero after the sweep
        for (int a = 0; a < 16; a++) op(1'b1, 1'b0, a, 8'h00, "init.rd");
        op(1'b0, 1'b0, 0, 8'h00, "init.idle");

        // Write then read, then idle hold
        op(1'b1, 1'b1, 3, 8'hA5, "a5.wr");
        op(1'b1, 1'b0, 3, 8'h00, "a5.rd");
        op(1'b0, 1'b0, 3, 8'h00, "a5.hold");

        // Random traffic, back-to-back reads and read-after-write included
        for (int i = 0; i < 80; i++) begin
            op(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), 8'($urandom), "rand");
        end
        op(1'b1, 1'b1, 9, 8'h3E, "raw.wr");
        op(1'b1, 1'b0, 9, 8'h00, "raw.rd");

        // Fill, then clear with a simultaneous write that must be dropped
        for (int a = 0; a < 16; a++) op(1'b1, 1'b1, a, 8'(a) ^ 8'h3C, "fill");
        b.clear = 1'b1; b.enable = 1'b1; b.write_enable = 1'b1;
        b.address = 4'h0; b.data_in = 8'hFF;
        tick();
        b.clear = 1'b0;
        check("clr.busy0", {31'h0, b.busy}, 32'h1);
        check("clr.rv",    {31'h0, b.rd_valid}, 32'h0);
        sweep_check("clr.busy", 1'b1);
        model_clear();
        for (int a = 0; a < 16; a++) op(1'b1, 1'b0, a, 8'h00, "clr.rd");

        // DEPTH=12: out-of-range write dropped, read returns zero
        b12.enable = 1'b1; b12.write_enable = 1'b1; b12.address = 4'd11; b12.data_in = 8'h55;
        tick();
        b12.address = 4'd13; b12.data_in = 8'h77;
        tick();
        b12.write_enable = 1'b0;
        tick();
        check("oor.dout", {24'h0, b12.data_out}, 32'h0);
        check("oor.rv",   {31'h0, b12.rd_valid}, 32'h1);
        check("oor.perr", {31'h0, b12.parity_err}, 32'h0);
        b12.address = 4'd11;
        tick();
        check("oor.a11", {24'h0, b12.data_out}, 32'h55);
        b12.enable = 1'b0;
        tick();
        check("oor.idle", {31'h0, b12.rd_valid}, 32'h0);

        // Reset while a read result is on the outputs
        op(1'b1, 1'b1, 2, 8'h5A, "rr.wr");
        op(1'b1, 1'b0, 2, 8'h00, "rr.rd");
        rst_n = 1'b0;
        #2;
        check("rr.dout", {24'h0, b.data_out}, 32'h0);
        check("rr.rv",   {31'h0, b.rd_valid}, 32'h0);
        check("rr.busy", {31'h0, b.busy},     32'h1);
        rst_n = 1'b1;
        sweep_check("rr.sweep", 1'b0);
        model_clear();
        exp_dout = 8'h00;

        // Reset in the middle of a clear sweep (ptr=7) restarts it
        for (int a = 0; a < 16; a++) op(1'b1, 1'b1, a, 8'hC3 ^ 8'(a), "mid.fill");
        b.clear = 1'b1;
        tick();
        b.clear = 1'b0;
        repeat (7) tick();
        check("mid.busy", {31'h0, b.busy}, 32'h1);
        rst_n = 1'b0;
        #2;
        check("mid.rst_busy", {31'h0, b.busy}, 32'h1);
        rst_n = 1'b1;
        sweep_check("mid.sweep", 1'b0);
        model_clear();
        for (int a = 0; a < 16; a++) op(1'b1, 1'b0, a, 8'h00, "mid.rd");

        // Parity corruption detection
        op(1'b1, 1'b1, 5, 8'h0F, "par.wr");
`ifdef DATA_MEMORY_PARITY_EN
        dut.mem_q[5][0] = ~dut.mem_q[5][0];
        b.enable = 1'b1; b.write_enable = 1'b0; b.address = 4'd5;
        tick();
        b.enable = 1'b0;
        check("par.dout", {24'h0, b.data_out}, 32'h0E);
        check("par.rv",   {31'h0, b.rd_valid}, 32'h1);
        check("par.perr", {31'h0, b.parity_err}, 32'h1);
`else
        op(1'b1, 1'b0, 5, 8'h00, "par.rd");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
